// File: rtl/cordic_pkg.sv
// Shared constants, widths, arctangent table and FSM state type for the
// vectoring-mode CORDIC (Cartesian -> angle/magnitude) block.
package cordic_pkg;

  localparam int ITER_N = 8;
  localparam int IN_W   = 8;
  localparam int XY_W   = 12;
  localparam int Z_W    = 11;
  localparam int ANG_W  = 9;
  localparam int MAG_W  = 10;
  localparam int CNT_W  = 3;

  // Angles in z are quarter-LSB units: 400 = 90 deg, 800 = 180 deg.
  localparam logic signed [Z_W-1:0] ANG_90 = 11'sd400;

  // Output-unit angle for the negative X axis (180 deg).
  localparam logic signed [ANG_W-1:0] ANG_180 = 9'sd200;

  // atan(2^-i) in quarter-LSB units.
  localparam logic signed [Z_W-1:0] ATAN_TBL [ITER_N] = '{
    11'sd200, 11'sd118, 11'sd62, 11'sd32, 11'sd16, 11'sd8, 11'sd4, 11'sd2
  };

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    POST = 2'd2
  } state_e;

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring micro-rotation: rotates (x,y) toward the +X axis by
// atan(2^-i) in the direction that shrinks |y|, accumulating the angle in z.
module cordic_vec_step
  import cordic_pkg::*;
(
  input  logic signed [XY_W-1:0]  x_i,
  input  logic signed [XY_W-1:0]  y_i,
  input  logic signed [Z_W-1:0]   z_i,
  input  logic        [CNT_W-1:0] i_i,
  output logic signed [XY_W-1:0]  x_o,
  output logic signed [XY_W-1:0]  y_o,
  output logic signed [Z_W-1:0]   z_o
);

  logic signed [XY_W-1:0] x_sh;
  logic signed [XY_W-1:0] y_sh;

  // Direction chosen by the sign of y; right-hand sides use the old x/y.
  always_comb begin
    x_sh = x_i >>> i_i;
    y_sh = y_i >>> i_i;
    if (!y_i[XY_W-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + ATAN_TBL[i_i];
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - ATAN_TBL[i_i];
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// Vectoring-mode CORDIC: converts signed 8-bit (xin,yin) into atan2 angle
// (1 LSB = 0.9 deg) and vector magnitude with a fixed 10-cycle latency.
// Optional macro CORDIC_GAIN_COMP_EN scales the magnitude by 39/64 to remove
// the CORDIC gain; without it the raw gained x is reported.
//
// Handshake: start is a request pulse honoured only in IDLE when done is
// low; inputs are captured on that edge only. busy is high from the
// accepting edge through the done cycle; done is a one-cycle pulse and
// angle/magnitude hold until the next done.
module cordic_vector
  import cordic_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [IN_W-1:0]  xin,
  input  logic signed [IN_W-1:0]  yin,
  output logic                    busy,
  output logic                    done,
  output logic signed [ANG_W-1:0] angle,
  output logic        [MAG_W-1:0] magnitude,
  output state_e                  dbg_state
);

  state_e                  state_q;
  logic                    busy_q, done_q;
  logic signed [ANG_W-1:0] angle_q;
  logic        [MAG_W-1:0] magnitude_q;
  logic signed [XY_W-1:0]  x_q, y_q;
  logic signed [Z_W-1:0]   z_q;
  logic        [CNT_W-1:0] cnt_q;
  logic                    zero_q, negx_q;

  logic signed [XY_W-1:0]  xs, ys, x_ld, y_ld, x_d, y_d;
  logic signed [Z_W-1:0]   z_ld, z_d;
  logic signed [Z_W:0]     ang_full;
  logic signed [XY_W+5:0]  x_w, x_c, mag_full;
  logic signed [ANG_W-1:0] angle_d;
  logic        [MAG_W-1:0] magnitude_d;
  logic                    unused_bits;

  // Inputs scaled by 4 (two fractional bits) and pre-rotated into the right half-plane.
  always_comb begin
    xs = {{(XY_W-IN_W-2){xin[IN_W-1]}}, xin, 2'b00};
    ys = {{(XY_W-IN_W-2){yin[IN_W-1]}}, yin, 2'b00};
    if (!xin[IN_W-1]) begin
      x_ld = xs;
      y_ld = ys;
      z_ld = '0;
    end else if (!yin[IN_W-1]) begin
      x_ld = ys;
      y_ld = -xs;
      z_ld = ANG_90;
    end else begin
      x_ld = -ys;
      y_ld = xs;
      z_ld = -ANG_90;
    end
  end

  cordic_vec_step u_step (
    .x_i (x_q),
    .y_i (y_q),
    .z_i (z_q),
    .i_i (cnt_q),
    .x_o (x_d),
    .y_o (y_d),
    .z_o (z_d)
  );

  // Final rounding of angle and (optionally gain-compensated) magnitude.
  always_comb begin
    ang_full = ({z_q[Z_W-1], z_q} + 12'sd2) >>> 2;
    angle_d  = ang_full[ANG_W-1:0];
    x_w      = {{6{x_q[XY_W-1]}}, x_q};
`ifdef CORDIC_GAIN_COMP_EN
    x_c      = ((x_w <<< 5) + (x_w <<< 2) + (x_w <<< 1) + x_w) >>> 6;
`else
    x_c      = x_w;
`endif
    mag_full    = (x_c + 18'sd2) >>> 2;
    magnitude_d = mag_full[MAG_W-1:0];
  end

  assign unused_bits = ^{ang_full[Z_W:ANG_W], mag_full[XY_W+5:MAG_W]};

  // Control FSM with datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      angle_q     <= '0;
      magnitude_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      negx_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          // A start coinciding with done is dropped; next cycle is free.
          if (start && !done_q) begin
            x_q     <= x_ld;
            y_q     <= y_ld;
            z_q     <= z_ld;
            cnt_q   <= '0;
            zero_q  <= (xin == '0) && (yin == '0);
            negx_q  <= xin[IN_W-1] && (yin == '0);
            busy_q  <= 1'b1;
            state_q <= ITER;
          end
        end
        ITER: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= POST;
        end
        POST: begin
          // The zero vector and the negative X axis have exact answers that
          // the truncated iteration would otherwise miss (residual z drift).
          if (zero_q)      angle_q <= '0;
          else if (negx_q) angle_q <= ANG_180;
          else             angle_q <= angle_d;
          magnitude_q <= magnitude_d;
          done_q      <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign angle     = angle_q;
  assign magnitude = magnitude_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: directed vectors with tolerance windows, protocol
// cases (busy start, start on done, mid-conversion reset) and randomized
// vectors checked against a behavioural reference model.
`timescale 1ns/1ps
module tb_cordic_vector;
  import cordic_pkg::*;

  logic              clk;
  logic              reset;
  logic              start;
  logic signed [7:0] xin;
  logic signed [7:0] yin;
  logic              busy;
  logic              done;
  logic signed [8:0] angle;
  logic        [9:0] magnitude;
  state_e            dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [18:0] exp_q[$];

  cordic_vector dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .xin       (xin),
    .yin       (yin),
    .busy      (busy),
    .done      (done),
    .angle     (angle),
    .magnitude (magnitude),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Vectoring CORDIC on plain integers: pre-rotate into x>=0, eight
  // sign-directed micro-rotations, then round the two fractional bits.
  function automatic void ref_model(input int xi, input int yi,
                                    output int ang, output int mag);
    int atan_q[8] = '{200, 118, 62, 32, 16, 8, 4, 2};
    int x, y, z, xn, yn, m;
    if (xi >= 0) begin
      x = xi * 4; y = yi * 4; z = 0;
    end else if (yi >= 0) begin
      x = yi * 4; y = -xi * 4; z = 400;
    end else begin
      x = -yi * 4; y = xi * 4; z = -400;
    end
    for (int i = 0; i < 8; i++) begin
      if (y >= 0) begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_q[i];
      end else begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_q[i];
      end
      x = xn; y = yn;
    end
    ang = (z + 2) >>> 2;
    if (xi == 0 && yi == 0) ang = 0;
    else if (xi < 0 && yi == 0) ang = 200;
`ifdef CORDIC_GAIN_COMP_EN
    m = (x * 39) >>> 6;
`else
    m = x;
`endif
    mag = (m + 2) >>> 2;
  endfunction

  // ---------------- checkers ----------------
  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one conversion and follows it to done. dup_at>0 pulses a second
  // start that many cycles after acceptance; start_on_done raises start in
  // the done cycle. Returns the observed angle/magnitude.
  task automatic convert(input logic signed [7:0] xv, input logic signed [7:0] yv,
                         input int dup_at, input bit start_on_done,
                         output int ang_o, output int mag_o);
    int ea, em, lat;
    bit seen;
    logic [18:0] e;
    ref_model(int'(xv), int'(yv), ea, em);
    exp_q.push_back({9'(ea), 10'(em)});
    xin = xv; yin = yv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    xin = 8'($urandom); yin = 8'($urandom);
    check("busy_at_accept", busy, 1);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      start = (dup_at != 0) && (lat + 1 == dup_at);
      if (start) begin xin = 8'($urandom); yin = 8'($urandom); end
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else check("busy_inflight", busy, 1);
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    e = exp_q.pop_front();
    ang_o = int'(angle);
    mag_o = int'(magnitude);
    if (seen) begin
      // done arrives 9 edges after the accepting edge: 10th cycle overall.
      check("latency", lat, 9);
      check("busy_in_done_cycle", busy, 1);
      check("angle", angle, $signed(e[18:10]));
      check("magnitude", magnitude, e[9:0]);
    end
    if (start_on_done) begin
      start = 1'b1; xin = 8'sd20; yin = 8'sd10;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int a, m, extra;
    logic signed [7:0] rx, ry;
    reset = 1'b1; start = 1'b0; xin = '0; yin = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_angle", angle, 0);
    check("reset_mag", magnitude, 0);
    check("reset_state", dbg_state, IDLE);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with spec tolerance windows.
    convert(8'sd39, 8'sd0, 0, 1'b0, a, m);
    check_rng("a_39_0", a, 0, 0);
`ifdef CORDIC_GAIN_COMP_EN
    check_rng("m_39_0", m, 38, 40);
`else
    check_rng("m_39_0_raw", m, 62, 66);
`endif
    convert(8'sd0, 8'sd39, 0, 1'b0, a, m);
    check_rng("a_0_39", a, 99, 101);
    convert(8'sd0, -8'sd39, 0, 1'b0, a, m);
    check_rng("a_0_m39", a, -101, -99);
    convert(8'sd39, 8'sd39, 0, 1'b0, a, m);
    check_rng("a_39_39", a, 49, 51);
`ifdef CORDIC_GAIN_COMP_EN
    check_rng("m_39_39", m, 53, 57);
`endif
    convert(-8'sd39, 8'sd0, 0, 1'b0, a, m);
    check_rng("a_m39_0", a, 200, 200);
    convert(-8'sd39, -8'sd39, 0, 1'b0, a, m);
    check_rng("a_m39_m39", a, -151, -149);
    convert(-8'sd128, -8'sd128, 0, 1'b0, a, m);
    check_rng("a_m128_m128", a, -151, -149);
    convert(8'sd0, 8'sd0, 0, 1'b0, a, m);
    check_rng("a_0_0", a, 0, 0);
    check_rng("m_0_0", m, 0, 0);
    convert(-8'sd128, 8'sd0, 0, 1'b0, a, m);
    check_rng("a_m128_0", a, 200, 200);

    // Second start while busy: ignored, exactly one done.
    convert(8'sd50, -8'sd70, 3, 1'b0, a, m);
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("dup_start_extra_done", extra, 0);

    // Start raised in the done cycle is dropped.
    convert(-8'sd17, 8'sd93, 0, 1'b1, a, m);
    check("start_on_done_state", dbg_state, IDLE);

    // Reset at cycle 5 of a conversion, with start also asserted on reset.
    xin = 8'sd60; yin = 8'sd25; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_angle", angle, 0);
    check("rst_mid_mag", magnitude, 0);
    extra = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check("rst_mid_no_done", extra, 0);

    // Randomized vectors against the reference model.
    for (int n = 0; n < 24; n++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      if (n == 0) ry = 8'sd0;
      if (n == 1) rx = -8'sd128;
      if (n == 2) begin rx = 8'sd127; ry = -8'sd128; end
      convert(rx, ry, 0, 1'b0, a, m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_vector.md
CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 xin  input  8  signed Cartesian X, two's complement.
REQ-006 yin  input  8  signed Cartesian Y, two's complement.
REQ-007 busy  output  1  high while a conversion is in flight.
REQ-008 done  output  1  single-cycle pulse when angle/magnitude are valid.
REQ-009 angle  output  9  signed atan2(yin,xin); 1 LSB = 0.9 deg (100 = 90 deg, same units as the sine block's angle input); range -200..+200.
REQ-010 magnitude  output  10  unsigned vector length; held until next done.

Function
REQ-011 The block SHALL implement vectoring-mode CORDIC, the inverse of the rotation-mode sine block: drive y to 0 and accumulate angle.
REQ-012 The FSM SHALL have states IDLE, ITER and POST, with transitions IDLE->ITER on start, ITER->POST after 8 iterations, and POST->IDLE unconditionally.
REQ-013 On the IDLE edge with start=1, it SHALL load x,y as 12-bit signed values equal to the input shifted left by 2, and z as 11-bit signed in quarter-LSB units.
REQ-014 Pre-rotation at load: xin>=0 gives x=xin, y=yin, z=0; xin<0 and yin>=0 gives x=yin, y=-xin, z=+400; xin<0 and yin<0 gives x=-yin, y=xin, z=-400.
REQ-015 Iteration i (0..7): if y>=0 then x+=y>>>i, y-=x>>>i, z+=ATAN[i]; else x-=y>>>i, y+=x>>>i, z-=ATAN[i]; arithmetic shifts, old x/y on the right-hand side.
REQ-016 The ATAN table SHALL hold the quarter-LSB values {200,118,62,32,16,8,4,2}.
REQ-017 In POST, angle SHALL be set to (z+2)>>>2, magnitude to the compensated or raw x (REQ-026/027) rounded off its 2 fractional bits, and done=1 for exactly one cycle.
REQ-018 Latency SHALL be fixed: start sampled at edge k gives done high in the cycle after edge k+9 (10 cycles).
REQ-019 busy SHALL be 1 from edge k through the done cycle inclusive and 0 otherwise.
REQ-020 start while busy=1 SHALL be ignored with no queueing, and inputs SHALL be sampled only at the accepting edge.
REQ-021 start in the same cycle as done SHALL be ignored; a new request is accepted from the next cycle.
REQ-022 xin=yin=0 SHALL produce angle=0 and magnitude=0.
REQ-023 xin<0 with yin=0 SHALL produce angle=+200; xin=-128 SHALL be handled without overflow (12-bit internal).

Reset
REQ-024 reset=1 SHALL force IDLE and clear busy, done, angle, magnitude, x, y, z and the iteration counter at the next edge.
REQ-025 Reset mid-conversion SHALL abort it with no done pulse, and start in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 With CORDIC_GAIN_COMP_EN defined, magnitude SHALL be x_final*39/64 (shift-add 32+4+2+1, then >>6), which removes the 1.647 gain; the maximum is 182.
REQ-027 Without CORDIC_GAIN_COMP_EN, magnitude SHALL be raw x_final (gain about 1.647, maximum about 299), and latency SHALL be unchanged.

Structure
REQ-028 Shared package cordic_pkg SHALL hold ITER_N=8, the ATAN quarter-LSB table, the widths (IN_W=8, XY_W=12, Z_W=11, ANG_W=9, MAG_W=10), the ANG_90 quarter-LSB constant (400) and the FSM state enum.
REQ-029 One combinational sub-module, cordic_vec_step, SHALL perform a single micro-rotation (x,y,z,i in; x,y,z out), shared across iterations.

Verification
REQ-030 With the macro defined: (39,0) -> angle 0, magnitude 39+/-1, done at start+10 cycles.
REQ-031 (0,39) -> angle 100+/-1; (0,-39) -> angle -100+/-1; (39,39) -> angle 50+/-1, magnitude 55+/-2.
REQ-032 (-39,0) -> angle 200; (-39,-39) -> angle -150+/-1; (-128,-128) -> no overflow, angle -150+/-1.
REQ-033 Second start pulse during busy -> ignored, exactly one done; reset asserted at cycle 5 of a conversion -> no done, all outputs 0.
REQ-034 Macro undefined: (39,0) -> magnitude 64+/-2, same latency; (0,0) -> angle 0, magnitude 0 in both builds.
